// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/response channel, redirect/stall
// control from the pipeline, the ID-stage output, and a debug view of internal state.
interface mips_fetch_unit_if #(
  parameter int PC_WIDTH = 64,
  parameter int DEPTH    = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a request transfers on a rising edge where imem_req_valid && imem_req_ready.
  // Once raised, valid and addr hold until that transfer unless a redirect intervenes.
  // imem_resp_valid has no backpressure. An ID entry is consumed on an edge where
  // id_valid && !stall.
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [PC_WIDTH-1:0] imem_req_addr;
  logic                imem_resp_valid;
  logic [31:0]         imem_resp_data;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                stall;
  logic                id_valid;
  logic [31:0]         id_inst;
  logic [PC_WIDTH-1:0] id_pc;
  logic [PC_WIDTH-1:0] id_pc4;
  logic                id_addr_err;

  logic                dbg_err_state;
  logic [CW-1:0]       dbg_outstanding;
  logic [CW-1:0]       dbg_discard;
  logic [CW-1:0]       dbg_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, stall,
    output id_valid, id_inst, id_pc, id_pc4, id_addr_err,
    output dbg_err_state, dbg_outstanding, dbg_discard, dbg_count
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, stall,
    input  id_valid, id_inst, id_pc, id_pc4, id_addr_err,
    input  dbg_err_state, dbg_outstanding, dbg_discard, dbg_count
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: in-order word requests to instruction memory, a
// small response FIFO feeding ID, redirect with stale-response discard, and AdEL markers.
module mips_fetch_unit #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  DEPTH    = 2
) (
  input logic             clock,
  input logic             reset,
  mips_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]         DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [PC_WIDTH-1:0] FOUR    = PC_WIDTH'(4);

  typedef enum logic {ST_FETCH, ST_ERR} state_t;

  state_t              state;
  logic                err_pending;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] resp_pc;
  logic [PC_WIDTH-1:0] err_pc;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       discard;
  logic [CW-1:0]       count;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;

  logic [31:0]         fifo_inst [DEPTH];
  logic [PC_WIDTH-1:0] fifo_pc   [DEPTH];
  logic                fifo_err  [DEPTH];

  logic [CW:0]         occupancy;
  logic                req_fire;
  logic                resp_fire;
  logic                live_push;
  logic                err_push;
  logic                push;
  logic                pop;
  logic                misaligned;
  logic [31:0]         push_inst;
  logic [PC_WIDTH-1:0] push_pc;
  logic [PC_WIDTH-1:0] redirect_aligned;

  always_comb begin
    occupancy          = {1'b0, outstanding} + {1'b0, count};
    bus.imem_req_valid = !reset && (state == ST_FETCH) && (occupancy < DEPTH_W);
    bus.imem_req_addr  = fetch_pc;
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    // Responses with nothing outstanding are leftovers from before reset.
    resp_fire          = !reset && bus.imem_resp_valid && (outstanding != '0);
    live_push          = resp_fire && (discard == '0) && !bus.redirect_valid;
    // The AdEL marker waits until every pre-redirect response has drained.
    err_push           = err_pending && (discard == '0) && (count == '0) && !bus.redirect_valid;
    push               = live_push || err_push;
    push_inst          = live_push ? bus.imem_resp_data : 32'h0;
    push_pc            = live_push ? resp_pc : err_pc;
    misaligned         = bus.redirect_pc[1:0] != 2'b00;
    redirect_aligned   = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};

    bus.id_valid    = !reset && (count != '0);
    pop             = bus.id_valid && !bus.stall;
    bus.id_inst     = bus.id_valid ? fifo_inst[rd_ptr] : 32'h0;
    bus.id_pc       = bus.id_valid ? fifo_pc[rd_ptr] : '0;
    bus.id_pc4      = bus.id_valid ? fifo_pc[rd_ptr] + FOUR : '0;
    bus.id_addr_err = bus.id_valid && fifo_err[rd_ptr];

    bus.dbg_err_state   = (state == ST_ERR);
    bus.dbg_outstanding = outstanding;
    bus.dbg_discard     = discard;
    bus.dbg_count       = count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_FETCH;
      err_pending <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      err_pc      <= '0;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
      if (bus.redirect_valid) begin
        // Every request still in flight after this edge belongs to the old stream.
        discard     <= outstanding + CW'(req_fire) - CW'(resp_fire);
        fetch_pc    <= redirect_aligned;
        resp_pc     <= redirect_aligned;
        err_pc      <= bus.redirect_pc;
        state       <= misaligned ? ST_ERR : ST_FETCH;
        err_pending <= misaligned;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + FOUR;
        if (resp_fire && (discard != '0))
          discard <= discard - CW'(1);
        if (live_push)
          resp_pc <= resp_pc + FOUR;
        if (err_push)
          err_pending <= 1'b0;
        if (push) begin
          fifo_inst[wr_ptr] <= push_inst;
          fifo_pc[wr_ptr]   <= push_pc;
          fifo_err[wr_ptr]  <= !live_push;
          wr_ptr            <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // The request throttle keeps outstanding + buffered within DEPTH, so a full FIFO never sees a push.
  assert property (@(posedge clock) disable iff (reset) !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: in-order variable-latency memory model, expected
// instruction streams per redirect segment, and a negedge monitor that pops and compares.
module tb_mips_fetch_unit;
  localparam int          PW       = 64;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          EW       = 32 + PW + 1;
  localparam int          SEG      = 600;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mips_fetch_unit_if #(.PC_WIDTH(PW), .DEPTH(DEPTH)) bus ();

  mips_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q[$];
  logic [63:0]   pend_addr[$];
  int            pend_due[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat_lo = 1, lat_hi = 1, ready_pct = 100;
  bit no_req = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected ID stream after a (re)start at target: sequential words, or one AdEL marker.
  task automatic new_segment(logic [63:0] target);
    exp_t e;
    exp_q.delete();
    if (target[1:0] != 2'b00) begin
      e = '{inst: 32'h0, pc: target, err: 1'b1};
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < SEG; i++) begin
        e.pc   = target + 64'(4 * i);
        e.inst = mem_word(e.pc);
        e.err  = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect(logic [63:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    tick();
    bus.redirect_valid = 1'b0;
    new_segment(t);
    no_req = (t[1:0] != 2'b00);
  endtask

  task automatic do_reset(int n);
    bus.redirect_valid = 1'b0;
    reset = 1'b1;
    repeat (n) tick();
    reset  = 1'b0;
    no_req = 1'b0;
    new_segment(RESET_PC);
  endtask

  task automatic random_phase(int n);
    logic [63:0] t;
    for (int i = 0; i < n; i++) begin
      bus.stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 4) begin
        t = {$urandom, $urandom};
        t[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        redirect(t);
      end else begin
        tick();
      end
    end
  endtask

  // Monitor + memory model, both evaluated mid-cycle for the coming rising edge.
  initial begin
    logic        prev_valid, prev_ready, prev_redir, prev_rst, prev_idv, prev_stall;
    logic [63:0] prev_addr, prev_pc;
    logic [31:0] prev_inst;
    exp_t        e;
    prev_valid = 0; prev_ready = 0; prev_redir = 0; prev_rst = 1; prev_idv = 0; prev_stall = 0;
    prev_addr = '0; prev_pc = '0; prev_inst = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_id_valid", bus.id_valid, 0);
        check("rst_id_inst", bus.id_inst, 0);
        check("rst_id_pc", bus.id_pc, 0);
        check("rst_id_pc4", bus.id_pc4, 0);
        check("rst_id_addr_err", bus.id_addr_err, 0);
      end else begin
        if (bus.imem_req_valid)
          check("req_addr_align", bus.imem_req_addr[1:0], 0);
        if (no_req)
          check("req_after_adel", bus.imem_req_valid, 0);
        if (prev_valid && !prev_ready && !prev_redir && !prev_rst) begin
          check("req_hold_valid", bus.imem_req_valid, 1);
          check("req_hold_addr", bus.imem_req_addr, prev_addr);
        end
        if (!bus.id_valid)
          check("idle_inst_nop", bus.id_inst, 0);
        if (prev_idv && prev_stall && !prev_redir && !prev_rst) begin
          check("stall_hold_valid", bus.id_valid, 1);
          check("stall_hold_pc", bus.id_pc, prev_pc);
          check("stall_hold_inst", bus.id_inst, prev_inst);
        end
        if (bus.id_valid && !bus.stall) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL id_unexpected: got pc %h, expected no entry (t=%0t)", bus.id_pc, $time);
          end else begin
            e = exp_q.pop_front();
            check("id_pc", bus.id_pc, e.pc);
            check("id_inst", bus.id_inst, e.inst);
            check("id_pc4", bus.id_pc4, e.pc + 64'd4);
            check("id_addr_err", bus.id_addr_err, e.err);
          end
        end
      end

      if (reset) begin
        pend_addr.delete();
        pend_due.delete();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom;
      end else begin
        bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = mem_word(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          bus.imem_resp_valid = 1'b0;
          bus.imem_resp_data  = $urandom;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          pend_addr.push_back(bus.imem_req_addr);
          pend_due.push_back(cyc + 1 + int'($urandom_range(lat_lo, lat_hi)));
        end
      end

      prev_valid = bus.imem_req_valid;
      prev_ready = bus.imem_req_ready;
      prev_addr  = bus.imem_req_addr;
      prev_redir = bus.redirect_valid;
      prev_rst   = reset;
      prev_idv   = bus.id_valid;
      prev_stall = bus.stall;
      prev_pc    = bus.id_pc;
      prev_inst  = bus.id_inst;
    end
  end

  initial begin
    reset               = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.stall           = 1'b0;

    // Zero-wait memory, first entry two edges after release.
    do_reset(3);
    tick();
    tick();
    check("first_fetch_valid", bus.id_valid, 1);
    check("first_fetch_pc", bus.id_pc, RESET_PC);
    repeat (30) tick();

    // Hold stall with the FIFO full: requests stop, nothing lost afterwards.
    bus.stall = 1'b1;
    repeat (6) tick();
    check("stall_full_count", bus.dbg_count, DEPTH);
    check("stall_full_no_req", bus.imem_req_valid, 0);
    bus.stall = 1'b0;
    repeat (10) tick();

    // Latency-3 memory, redirect while two requests are in flight.
    lat_lo = 3; lat_hi = 3;
    do_reset(2);
    tick();
    tick();
    check("lat3_outstanding", bus.dbg_outstanding, 2);
    redirect(64'h1000);
    repeat (20) tick();

    // Redirect coinciding with a response and a request handshake.
    lat_lo = 1; lat_hi = 1;
    do_reset(2);
    tick();
    redirect(64'h4000);
    check("same_cycle_discard", bus.dbg_discard, 1);
    repeat (15) tick();

    // Misaligned target: AdEL marker only, no further requests, then resume.
    redirect(64'h2002);
    repeat (20) tick();
    check("adel_entry_consumed", exp_q.size(), 0);
    check("adel_err_state", bus.dbg_err_state, 1);
    redirect(64'h3000);
    repeat (20) tick();
    check("resume_err_state", bus.dbg_err_state, 0);

    // PC wraps modulo 2^64.
    redirect(64'hFFFF_FFFF_FFFF_FFF0);
    repeat (20) tick();

    // Randomized traffic: backpressure, latency 1-4, random stalls and redirects.
    lat_lo = 1; lat_hi = 4; ready_pct = 70;
    random_phase(400);
    bus.stall = 1'b0;
    redirect(64'h8000);
    repeat (30) tick();

    // Reset mid-stream with the FIFO full; fetch restarts at RESET_PC.
    lat_lo = 1; lat_hi = 1; ready_pct = 100;
    bus.stall = 1'b1;
    repeat (6) tick();
    check("pre_reset_full", bus.dbg_count, DEPTH);
    bus.stall = 1'b0;
    do_reset(2);
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the architectural fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel. Responses return in order, with variable latency.
- Buffers returned instructions in a small FIFO and presents one {inst, pc, pc+4} per cycle to the ID stage. Supports stall, redirect (jump/branch/exception/ERET), and misaligned-target detection.

Parameters:
- PC_WIDTH, 64, width of PC and addresses.
- RESET_PC, 64'h0, first fetch address after reset.
- DEPTH, 2, FIFO entries; also the cap on outstanding requests plus buffered entries (power of two, ≥2).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  PC_WIDTH  word-aligned fetch address (bits [1:0] always 0).
- imem_resp_valid  input  1  one in-order response this cycle.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  change fetch stream (from branch/jump/CP0 logic).
- redirect_pc  input  PC_WIDTH  new target.
- stall  input  1  ID stage cannot consume this cycle (hazard unit).
- id_valid  output  1  id_* fields hold a live instruction.
- id_inst  output  32  instruction to decoder; 32'h0 (NOP) when !id_valid.
- id_pc  output  PC_WIDTH  address of id_inst.
- id_pc4  output  PC_WIDTH  id_pc + 4 (link value).
- id_addr_err  output  1  entry is a fetch-address error marker (AdEL).

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; err_state=0.
  - During the reset cycle: imem_req_valid=0, id_valid=0, id_inst=0, id_pc=0, id_pc4=0, id_addr_err=0.
  - Memory is reset by the same signal. Any response arriving while outstanding==0 is ignored.
- Request issue:
  - imem_req_valid=1 iff !reset && !err_state && (outstanding + count) < DEPTH.
  - imem_req_addr = fetch_pc.
  - On handshake (valid && ready), fetch_pc += 4 and outstanding += 1.
  - Address and valid stay stable while ready=0, unless a redirect occurs.
- Response:
  - On imem_resp_valid: outstanding -= 1.
  - If discard>0, the response is dropped and discard -= 1.
  - Otherwise, push {resp_data, pc of oldest live request, err=0}. Response pcs are tracked with a resp_pc register, advanced by 4 per accepted live response.
  - A push into a full FIFO cannot occur by construction; add an assertion.
  - No bypass: minimum latency is request handshake at cycle t, response at t+k, id_valid at t+k+1.
- ID output:
  - id_valid = count>0; id_* show the FIFO head.
  - Pop when id_valid && !stall.
  - Push and pop in the same cycle are both honoured, and count is unchanged.
- Redirect (highest priority, same-cycle effect on next state):
  - FIFO flushed.
  - discard = outstanding − (1 if a response arrives this cycle) + (1 if a request handshakes this cycle).
  - fetch_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00} and resp_pc = the same value.
  - A pop and a redirect in the same cycle: the pop occurs, then the flush.
  - imem_req_valid stays asserted on the redirect cycle with the old address; that request is counted in discard.
- Misaligned redirect (redirect_pc[1:0] ≠ 0):
  - Flush as above and set err_state=1 (no further requests).
  - Once discard reaches 0 and the FIFO is empty, push one entry {inst=0, pc=redirect_pc unmodified, err=1}.
  - err_state holds until the next redirect.
- Counters:
  - outstanding and discard are each log2(DEPTH)+1 bits and never exceed DEPTH.
  - PC arithmetic wraps modulo 2^PC_WIDTH.

Test Plan:
- Zero-wait memory (ready=1, response 1 cycle after request), stall=0 from reset → id_pc = 0x0, 0x4, 0x8… one per cycle from the 3rd cycle after reset release; id_pc4 = id_pc+4.
- stall=1 held 5 cycles with FIFO full (DEPTH=2) → imem_req_valid=0, id_pc frozen at 0x8, no response lost. After release, 0x8 and 0xC are delivered consecutively.
- Latency 3 memory, redirect to 0x1000 while 2 requests are outstanding → both stale responses dropped, next id_valid carries pc 0x1000, and no 0x0/0x4 instruction is ever presented.
- Redirect on the same cycle as a response and a request handshake → discard=outstanding−1+1, and the first delivered pc equals the redirect target.
- Redirect to 0x2002 → no requests issued afterwards; one entry id_addr_err=1, id_pc=0x2002, id_inst=0. A later redirect to 0x3000 resumes normal fetch.
- reset asserted mid-stream with the FIFO full → next cycle id_valid=0 and imem_req_valid=0. After release, fetch restarts at RESET_PC.
